// File: rtl/m_imem_loader_if.sv
// Instruction-memory write port carried from the loader to the imem.
// Purely combinational bundle; no latency of its own.
// No backpressure: the memory must accept every write strobe.
interface m_imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [31:0]       w_wdata;

    modport master (output w_addr, output w_we, output w_wdata);
    modport slave  (input  w_addr, input  w_we, input  w_wdata);
endinterface

// File: rtl/m_imem_loader.sv
// UART (8N1) program loader: 16-bit LE word count, then LE words written to imem from addr 0.
// Latency: a word is written the cycle after its 4th byte's stop-bit sample; done follows one cycle later.
// No backpressure: UART has no flow control and imem accepts a write every cycle.
module m_imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12   // must be <= 16: the word index is 16 bits
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_rxd,
    m_imem_loader_if.master    imem,
    output logic               w_busy,
    output logic               w_done,
    output logic               w_err
);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] CAP     = 17'(1) << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {S_HDR0, S_HDR1, S_DATA, S_DONE} ld_state_t;

    rx_state_t   rx_st;
    logic        rxd_s1, rxd_s2, rxd_q;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_sh;
    logic        byte_stb;
    logic        frm_err;

    ld_state_t         st;
    logic [15:0]       n;
    logic [15:0]       idx;
    logic [1:0]        lane;
    logic [23:0]       part;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [31:0]       wdata_r;

    // UART receiver: synchronize, find start edge, sample mid-bit, strobe good bytes or flag framing errors
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_q    <= 1'b1;
            rx_st    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_sh    <= '0;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rxd_s1   <= w_rxd;
            rxd_s2   <= rxd_s1;
            rxd_q    <= rxd_s2;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rxd_q && !rxd_s2) begin
                        rx_st <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        // line back high at mid-start means a glitch, not a character
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_st   <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        rx_sh   <= {rxd_s2, rx_sh[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        // re-arm right at the stop sample so a back-to-back start edge is not missed
                        cnt   <= '0;
                        rx_st <= RX_IDLE;
                        if (rxd_s2) byte_stb <= 1'b1;
                        else        frm_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Loader FSM: parse header, assemble words, issue imem writes, hold the CPU in reset until complete
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            st      <= S_HDR0;
            n       <= '0;
            idx     <= '0;
            lane    <= '0;
            part    <= '0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            w_busy  <= 1'b1;
            w_done  <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (st)
                S_HDR0: begin
                    if (frm_err) begin
                        w_err <= 1'b1;
                    end else if (byte_stb) begin
                        n[7:0] <= rx_sh;
                        st     <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (frm_err) begin
                        w_err <= 1'b1;
                        st    <= S_HDR0;
                    end else if (byte_stb) begin
                        n[15:8] <= rx_sh;
                        if ({rx_sh, n[7:0]} == 16'd0) begin
                            // empty image: release the CPU straight away
                            st     <= S_DONE;
                            w_busy <= 1'b0;
                            w_done <= 1'b1;
                        end else begin
                            idx  <= '0;
                            lane <= '0;
                            st   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (frm_err) begin
                        w_err <= 1'b1;
                        lane  <= '0;
                        st    <= S_HDR0;
                    end else if (byte_stb) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: part[7:0]   <= rx_sh;
                            2'd1: part[15:8]  <= rx_sh;
                            2'd2: part[23:16] <= rx_sh;
                            default: begin
                                wdata_r <= {rx_sh, part};
                                addr_r  <= idx[ADDR_W-1:0];
                                // words past capacity are dropped rather than aliased onto low addresses
                                if ({1'b0, idx} < CAP) we_r  <= 1'b1;
                                else                   w_err <= 1'b1;
                                idx <= idx + 16'd1;
                                if (idx + 16'd1 == n) st <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    // entered on the last word's strobe, so this lands one cycle after that write
                    w_busy <= 1'b0;
                    w_done <= 1'b1;
                end
                default: st <= S_HDR0;
            endcase
        end
    end

    assign imem.w_addr  = addr_r;
    assign imem.w_we    = we_r;
    assign imem.w_wdata = wdata_r;
endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader at 8 clocks per UART bit.
// Two loaders share the serial line: a 12-bit-address one and a 2-bit-address one for overflow.
// Writes are logged on the falling edge; checks are taken 1 ns after a falling edge.
module tb_m_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int we_cyc_a = -1;
    int done_cyc_a = -1;
    logic done_a_prev = 1'b0;

    logic [11:0] wa_a[$];
    logic [31:0] wd_a[$];
    logic [1:0]  wa_b[$];
    logic [31:0] wd_b[$];
    logic [7:0]  bq[$];

    m_imem_loader_if #(.ADDR_W(12)) imem_a ();
    m_imem_loader_if #(.ADDR_W(2))  imem_b ();

    m_imem_loader #(.CLKS_PER_BIT(8), .ADDR_W(12)) dut_a (
        .w_clk(clk), .w_rst(rst_n), .w_rxd(rxd), .imem(imem_a),
        .w_busy(busy_a), .w_done(done_a), .w_err(err_a)
    );

    m_imem_loader #(.CLKS_PER_BIT(8), .ADDR_W(2)) dut_b (
        .w_clk(clk), .w_rst(rst_n), .w_rxd(rxd), .imem(imem_b),
        .w_busy(busy_b), .w_done(done_b), .w_err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // log every write cycle and the cycle where done rises
    always @(negedge clk) begin
        if (imem_a.w_we === 1'b1) begin
            wa_a.push_back(imem_a.w_addr);
            wd_a.push_back(imem_a.w_wdata);
            we_cyc_a = cyc;
        end
        if (done_a === 1'b1 && done_a_prev !== 1'b1) done_cyc_a = cyc;
        done_a_prev = done_a;
        if (imem_b.w_we === 1'b1) begin
            wa_b.push_back(imem_b.w_addr);
            wd_b.push_back(imem_b.w_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (8) @(negedge clk);
        end
        stop_cyc = cyc;
        rxd = stop;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
        we_cyc_a = -1;
        done_cyc_a = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        clear_logs();
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr",  32'(imem_a.w_addr), 32'h0);
        chk("rst_we",    32'(imem_a.w_we),   32'h0);
        chk("rst_wdata", imem_a.w_wdata,     32'h0);
        chk("rst_busy",  32'(busy_a),        32'h1);
        chk("rst_done",  32'(done_a),        32'h0);
        chk("rst_err",   32'(err_a),         32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();

        // 1: two-word image, back-to-back bytes
        bq = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h0a, 8'h20};
        send_bytes(bq);
        chk("t1_nwr", 32'(wa_a.size()), 32'd2);
        if (wa_a.size() == 2) begin
            chk("t1_addr0", 32'(wa_a[0]), 32'h0);
            chk("t1_data0", wd_a[0],      32'h20010020);
            chk("t1_addr1", 32'(wa_a[1]), 32'h1);
            chk("t1_data1", wd_a[1],      32'h200a0001);
        end
        chk("t1_done_after_we", 32'(done_cyc_a - we_cyc_a), 32'd1);
        chk("t1_we_timing_ok", 32'((we_cyc_a - stop_cyc >= 4) && (we_cyc_a - stop_cyc <= 12)), 32'd1);
        chk("t1_done", 32'(done_a), 32'h1);
        chk("t1_busy", 32'(busy_a), 32'h0);
        chk("t1_err",  32'(err_a),  32'h0);

        // 2: empty image
        do_reset();
        bq = '{8'h00, 8'h00};
        send_bytes(bq);
        chk("t2_nwr",  32'(wa_a.size()), 32'd0);
        chk("t2_done", 32'(done_a), 32'h1);
        chk("t2_busy", 32'(busy_a), 32'h0);
        chk("t2_done_timing_ok", 32'((done_cyc_a - stop_cyc >= 4) && (done_cyc_a - stop_cyc <= 12)), 32'd1);

        // 3: framing error mid-word, then a clean image
        do_reset();
        bq = '{8'h01, 8'h00, 8'h11};
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        chk("t3_err",  32'(err_a),  32'h1);
        chk("t3_nwr",  32'(wa_a.size()), 32'd0);
        chk("t3_busy", 32'(busy_a), 32'h1);
        chk("t3_done", 32'(done_a), 32'h0);
        bq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes(bq);
        chk("t3_nwr2", 32'(wa_a.size()), 32'd1);
        if (wa_a.size() == 1) begin
            chk("t3_addr", 32'(wa_a[0]), 32'h0);
            chk("t3_data", wd_a[0],      32'h12345678);
        end
        chk("t3_done2",   32'(done_a), 32'h1);
        chk("t3_err_sticky", 32'(err_a), 32'h1);

        // 4: short low glitch while idle is ignored
        do_reset();
        chk("t4_err_cleared", 32'(err_a), 32'h0);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("t4_glitch_err",  32'(err_a),  32'h0);
        chk("t4_glitch_busy", 32'(busy_a), 32'h1);
        bq = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
        send_bytes(bq);
        chk("t4_nwr", 32'(wa_a.size()), 32'd1);
        if (wa_a.size() == 1) chk("t4_data", wd_a[0], 32'hdeadbeef);
        chk("t4_done", 32'(done_a), 32'h1);
        chk("t4_err",  32'(err_a),  32'h0);

        // 5: reset in the middle of an image
        do_reset();
        bq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_bytes(bq);
        chk("t5_nwr", 32'(wa_a.size()), 32'd1);
        chk("t5_pre_wdata", imem_a.w_wdata, 32'h44332211);
        chk("t5_pre_busy", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_addr",  32'(imem_a.w_addr), 32'h0);
        chk("t5_rst_we",    32'(imem_a.w_we),   32'h0);
        chk("t5_rst_wdata", imem_a.w_wdata,     32'h0);
        chk("t5_rst_busy",  32'(busy_a),        32'h1);
        chk("t5_rst_done",  32'(done_a),        32'h0);
        chk("t5_rst_err",   32'(err_a),         32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        bq = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
        send_bytes(bq);
        chk("t5_nwr2", 32'(wa_a.size()), 32'd1);
        if (wa_a.size() == 1) begin
            chk("t5_addr", 32'(wa_a[0]), 32'h0);
            chk("t5_data", wd_a[0],      32'hddccbbaa);
        end
        chk("t5_done", 32'(done_a), 32'h1);

        // 6: overflow on the 4-word loader
        do_reset();
        bq = '{8'h05, 8'h00};
        for (int k = 0; k < 5; k++) begin
            bq.push_back(8'(k));
            bq.push_back(8'hc0);
            bq.push_back(8'hb0);
            bq.push_back(8'ha0);
        end
        send_bytes(bq);
        chk("t6_nwr", 32'(wa_b.size()), 32'd4);
        if (wa_b.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t6_addr%0d", k), 32'(wa_b[k]), 32'(k));
                chk($sformatf("t6_data%0d", k), wd_b[k], 32'ha0b0c000 | 32'(k));
            end
        end
        chk("t6_err",  32'(err_b),  32'h1);
        chk("t6_done", 32'(done_b), 32'h1);
        chk("t6_busy", 32'(busy_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/m_imem_loader.md
# m_imem_loader

Serial program loader that receives a UART byte stream from the board and writes 32-bit words into the processor's instruction memory write port, starting at word address 0. While loading, it holds the processor in reset through `w_busy`. When the image is complete it raises `w_done` and releases the processor. It sits between the board RX pin and the imem write port (`w_addr`/`w_we`/`w_din`) in the top-level board wrapper.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `ADDR_W`, default 12: word-address width; capacity is 2^ADDR_W words.
- `w_clk`, in, 1: clock; all state changes on rising edge.
- `w_rst`, in, 1: reset, asynchronous, active-low.
- `w_rxd`, in, 1: UART serial input; idle high; 8N1, LSB first; asynchronous to `w_clk`.
- `w_addr`, out, ADDR_W: imem word address for the current write.
- `w_we`, out, 1: imem write enable; one-cycle pulse per word.
- `w_wdata`, out, 32: imem write data.
- `w_busy`, out, 1: 1 while loading; drives processor reset.
- `w_done`, out, 1: 1 once the image is fully written.
- `w_err`, out, 1: sticky error flag (framing error or overflow).

## Operation
- Stream format: 2-byte word count N, little-endian. Then 4N data bytes; each word is little-endian (first byte = bits 7:0, fourth byte = bits 31:24).
- Word k is written to address k.
- Reset values: `w_addr`=0, `w_we`=0, `w_wdata`=0, `w_busy`=1, `w_done`=0, `w_err`=0. The loader state is S_HDR0.
- UART RX:
  - 2-FF synchronizer on `w_rxd`.
  - Start detect on a synchronized high→low transition while the RX is idle.
  - Start bit is checked at CLKS_PER_BIT/2 (integer division). If it is high, this is a false start: return to RX idle, no error.
  - 8 data bits are sampled every CLKS_PER_BIT cycles thereafter, then the stop bit.
  - At the stop sample:
    - stop=1: the byte is accepted (one-cycle internal strobe).
    - stop=0: framing error, byte discarded.
  - RX re-arms for the next start immediately after the stop sample.
- Loader FSM:
  - S_HDR0: accept byte → N[7:0]; go to S_HDR1.
  - S_HDR1: accept byte → N[15:8]. If N==0, go to S_DONE. Otherwise clear the word index and byte lane, and go to S_DATA.
  - S_DATA: each byte fills lane 0..3 of the word shift register. On lane 3:
    - Present the word with `w_addr` = word index.
    - Pulse `w_we`, unless the index ≥ 2^ADDR_W; in that case no write and `w_err`←1.
    - Increment the index. When index+1 == N, go to S_DONE.
  - S_DONE: `w_busy`=0, `w_done`=1. All further bytes are ignored until reset.
- A framing error in any of S_HDR0/S_HDR1/S_DATA sets `w_err`, discards any partial word and header, and returns to S_HDR0. `w_busy` stays 1.
- A framing error in S_DONE is ignored.
- `w_err` clears only on reset.
- The index is 16 bits. `w_addr` is index[ADDR_W-1:0] and does not wrap-write, because of the overflow rule above.

## Timing
- Byte accept occurs at the stop-bit mid-sample: about 9.5 bit times after the start edge, plus 2 synchronizer cycles.
- `w_we` is high exactly one cycle: the cycle after the accept strobe of a word's 4th byte.
- `w_addr`/`w_wdata` are valid in that cycle and hold until the next write.
- `w_busy` falls and `w_done` rises together, in the cycle after the final `w_we`. For N=0 they change in the cycle after the second header byte is accepted.
- Back-to-back bytes with a single stop bit and no idle gap are accepted without loss.
- Reset assertion forces all outputs to their reset values asynchronously, mid-byte or mid-word included. After release, the loader expects a fresh header.

## Test plan
Use CLKS_PER_BIT=8 in all cases.
1. Bytes 02 00 20 00 01 20 01 00 0a 20 → `w_we` at addr 0 with data 0x20010020, then `w_we` at addr 1 with data 0x200a0001. `w_done`=1 and `w_busy`=0 one cycle after the second `w_we`; `w_err`=0.
2. Bytes 00 00 → no `w_we`; `w_done` rises one cycle after the second accept.
3. Framing error:
   - Send 01 00 11, then a byte with stop bit 0 → `w_err`=1, no `w_we`, `w_busy`=1.
   - Then send 01 00 78 56 34 12 → write to addr 0 with data 0x12345678; `w_done`=1; `w_err` stays 1.
4. Low glitch of 3 cycles on `w_rxd` while idle → no byte accepted and no error. A following valid stream of 01 00 + 4 bytes loads normally.
5. Assert `w_rst` low after header 02 00 and 5 data bytes (first word written) → all outputs immediately at reset values. A new stream of 01 00 aa bb cc dd writes 0xddccbbaa to addr 0.
6. ADDR_W=2, N=5 with words 0..4 → writes to addrs 0..3 only. The 5th word is not written and `w_err`=1; `w_done`=1 after the 5th word's lane-3 accept.
